// File: rtl/fib_mem_readback_checker.sv
// fib_mem_readback_checker
// Snoops the BRAM port-B reads issued by the Fibonacci memory-test FSM,
// regenerates the expected data sequence and address map locally, and
// checks every read. Results feed LED / 7-segment status displays.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | after reset, index 0, no transaction seen yet
// S_RUN  | pass in progress, transactions checked in index order
// S_DONE | all NUM_VALUES checks of the pass completed; only a read of
//        | ADDR0 starts a new pass, anything else is ignored
module fib_mem_readback_checker #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int NUM_VALUES = 17,
    parameter int ADDR0      = 0,
    parameter int ADDR1      = 1000,
    parameter int STRIDE     = 1024,
    parameter int READ_LAT   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              chk_valid,
    output logic              chk_ok,
    output logic [DATA_W-1:0] exp_data,
    output logic [DATA_W-1:0] last_data,
    output logic [7:0]        fail_cnt,
    output logic              error,
    output logic              done,
    output logic [7:0]        pass_cnt
);

    localparam int                IDX_W    = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VALUES - 1);
    localparam logic [ADDR_W-1:0] A0       = ADDR_W'(ADDR0);
    localparam logic [ADDR_W-1:0] A1       = ADDR_W'(ADDR1);
    localparam logic [ADDR_W-1:0] ASTEP    = ADDR_W'(STRIDE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // transaction detector history
    logic              prev_en_q, prev_en_d;
    logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;

    // sequence generator: next index, Fibonacci pair and expected address
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              issued_all_q, issued_all_d;
    logic [DATA_W-1:0] fa_q, fa_d;
    logic [DATA_W-1:0] fb_q, fb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // read-latency pipe: valid, address match, last-of-pass flag, expected data
    logic [READ_LAT-1:0]             pv_q, pv_d;
    logic [READ_LAT-1:0]             pok_q, pok_d;
    logic [READ_LAT-1:0]             plast_q, plast_d;
    logic [READ_LAT-1:0][DATA_W-1:0] pexp_q, pexp_d;

    // registered results
    logic              chk_valid_q, chk_valid_d;
    logic              chk_ok_q, chk_ok_d;
    logic [DATA_W-1:0] exp_data_q, exp_data_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic [7:0]        fail_cnt_q, fail_cnt_d;
    logic              error_q, error_d;
    logic              done_q, done_d;
    logic [7:0]        pass_cnt_q, pass_cnt_d;

    logic              txn;
    logic              restart;
    logic              accept;
    logic [IDX_W-1:0]  cur_idx;
    logic [DATA_W-1:0] cur_fa;
    logic [DATA_W-1:0] cur_fb;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_last;
    logic              chk_fire;
    logic              chk_last;
    logic              chk_pass;
    logic [7:0]        fail_next;

    // A held enable with a stable address is one read; a new address or a
    // fresh enable edge starts another.
    assign txn     = rd_en && (!prev_en_q || (rd_addr != prev_addr_q));
    assign restart = (state_q == S_DONE) && txn && (rd_addr == A0);
    assign accept  = txn && ((state_q == S_IDLE) ||
                             ((state_q == S_RUN) && !issued_all_q) ||
                             restart);

    // A restarting transaction is checked as index 0 in the same cycle.
    assign cur_idx  = restart ? '0 : idx_q;
    assign cur_fa   = restart ? '0 : fa_q;
    assign cur_fb   = restart ? DATA_W'(1) : fb_q;
    assign cur_addr = restart ? A0 : addr_q;
    assign cur_last = (cur_idx == LAST_IDX);

    assign chk_fire  = pv_q[READ_LAT-1];
    assign chk_last  = plast_q[READ_LAT-1];
    assign chk_pass  = pok_q[READ_LAT-1] && (rd_data == pexp_q[READ_LAT-1]);
    assign fail_next = chk_pass ? fail_cnt_q :
                       ((fail_cnt_q == 8'hFF) ? 8'hFF : fail_cnt_q + 8'd1);

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (chk_fire && chk_last) state_d = S_DONE;
            S_DONE:  if (restart) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // sequence advance, latency pipe and result/counter updates
    always_comb begin
        prev_en_d    = rd_en;
        prev_addr_d  = rd_addr;
        idx_d        = idx_q;
        issued_all_d = issued_all_q;
        fa_d         = fa_q;
        fb_d         = fb_q;
        addr_d       = addr_q;

        pv_d    = pv_q;
        pok_d   = pok_q;
        plast_d = plast_q;
        pexp_d  = pexp_q;
        for (int i = READ_LAT - 1; i > 0; i--) begin
            pv_d[i]    = pv_q[i-1];
            pok_d[i]   = pok_q[i-1];
            plast_d[i] = plast_q[i-1];
            pexp_d[i]  = pexp_q[i-1];
        end
        pv_d[0]    = accept;
        pok_d[0]   = 1'b0;
        plast_d[0] = 1'b0;
        pexp_d[0]  = '0;

        chk_valid_d = chk_fire;
        chk_ok_d    = chk_ok_q;
        exp_data_d  = exp_data_q;
        last_data_d = last_data_q;
        fail_cnt_d  = fail_cnt_q;
        error_d     = error_q;
        done_d      = done_q;
        pass_cnt_d  = pass_cnt_q;

        if (restart) begin
            fail_cnt_d   = '0;
            done_d       = 1'b0;
            issued_all_d = 1'b0;
        end

        if (accept) begin
            pok_d[0]   = (rd_addr == cur_addr);
            plast_d[0] = cur_last;
            pexp_d[0]  = cur_fa;
            fa_d       = cur_fb;
            fb_d       = cur_fa + cur_fb;
            addr_d     = (cur_idx == '0) ? A1 : cur_addr + ASTEP;
            if (cur_last) begin
                idx_d        = cur_idx;
                issued_all_d = 1'b1;
            end else begin
                idx_d = cur_idx + 1'b1;
            end
        end

        if (chk_fire) begin
            chk_ok_d    = chk_pass;
            exp_data_d  = pexp_q[READ_LAT-1];
            last_data_d = rd_data;
            fail_cnt_d  = fail_next;
            if (!chk_pass) error_d = 1'b1;
            if (chk_last) begin
                done_d = 1'b1;
                if (fail_next == 8'd0) pass_cnt_d = pass_cnt_q + 8'd1;
            end
        end
    end

    // datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_en_q    <= 1'b0;
            prev_addr_q  <= '0;
            idx_q        <= '0;
            issued_all_q <= 1'b0;
            fa_q         <= '0;
            fb_q         <= DATA_W'(1);
            addr_q       <= A0;
            pv_q         <= '0;
            pok_q        <= '0;
            plast_q      <= '0;
            pexp_q       <= '0;
            chk_valid_q  <= 1'b0;
            chk_ok_q     <= 1'b0;
            exp_data_q   <= '0;
            last_data_q  <= '0;
            fail_cnt_q   <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            pass_cnt_q   <= '0;
        end else begin
            prev_en_q    <= prev_en_d;
            prev_addr_q  <= prev_addr_d;
            idx_q        <= idx_d;
            issued_all_q <= issued_all_d;
            fa_q         <= fa_d;
            fb_q         <= fb_d;
            addr_q       <= addr_d;
            pv_q         <= pv_d;
            pok_q        <= pok_d;
            plast_q      <= plast_d;
            pexp_q       <= pexp_d;
            chk_valid_q  <= chk_valid_d;
            chk_ok_q     <= chk_ok_d;
            exp_data_q   <= exp_data_d;
            last_data_q  <= last_data_d;
            fail_cnt_q   <= fail_cnt_d;
            error_q      <= error_d;
            done_q       <= done_d;
            pass_cnt_q   <= pass_cnt_d;
        end
    end

    assign chk_valid = chk_valid_q;
    assign chk_ok    = chk_ok_q;
    assign exp_data  = exp_data_q;
    assign last_data = last_data_q;
    assign fail_cnt  = fail_cnt_q;
    assign error     = error_q;
    assign done      = done_q;
    assign pass_cnt  = pass_cnt_q;

endmodule

// File: tb/tb_fib_mem_readback_checker.sv
// Testbench for fib_mem_readback_checker: drives port-B style reads with a
// one-cycle-latency memory and checks each reported result against a
// reference built from the Fibonacci closed rules and the address formula.
module tb_fib_mem_readback_checker;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 16;
    localparam int NUM_VALUES = 17;
    localparam int ADDR0      = 0;
    localparam int ADDR1      = 1000;
    localparam int STRIDE     = 1024;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data = '0;
    logic              chk_valid, chk_ok, error, done;
    logic [DATA_W-1:0] exp_data, last_data;
    logic [7:0]        fail_cnt, pass_cnt;

    fib_mem_readback_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_VALUES(NUM_VALUES),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .STRIDE(STRIDE), .READ_LAT(1)
    ) dut (
        .clock(clock), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .chk_valid(chk_valid), .chk_ok(chk_ok),
        .exp_data(exp_data), .last_data(last_data), .fail_cnt(fail_cnt),
        .error(error), .done(done), .pass_cnt(pass_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic              ok;
        logic [DATA_W-1:0] expv;
        logic [DATA_W-1:0] data;
        logic [7:0]        fail;
        logic              err;
        logic              dn;
        logic [7:0]        pass;
    } rec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    rec_t obs_q[$];
    rec_t exp_q[$];
    int   obs_cyc[$];

    // reference model state
    int                m_phase;   // 0 nothing seen, 1 in pass, 2 pass complete
    int                m_k;
    int                m_fail;
    int                m_pass;
    logic              m_err;
    logic [DATA_W-1:0] next_data = '0;

    always @(posedge clock) cyc <= cyc + 1;

    // record every result pulse together with the status seen alongside it
    always @(negedge clock) begin
        if (chk_valid === 1'b1) begin
            obs_q.push_back(rec_t'({chk_ok, exp_data, last_data, fail_cnt, error, done, pass_cnt}));
            obs_cyc.push_back(cyc);
        end
    end

    function automatic logic [DATA_W-1:0] fib(int k);
        logic [DATA_W-1:0] a, b, t;
        a = '0;
        b = DATA_W'(1);
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(int k);
        if (k == 0) return ADDR_W'(ADDR0);
        return ADDR_W'(ADDR1 + (k - 1) * STRIDE);
    endfunction

    function automatic string fmt(rec_t r);
        return $sformatf("ok=%b exp=%0d data=%0d fail=%0d err=%b done=%b pass=%0d",
                         r.ok, r.expv, r.data, r.fail, r.err, r.dn, r.pass);
    endfunction

    // reference: what one distinct read transaction should produce
    task automatic model_txn(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        logic ok, last;
        if (m_phase == 2 && a != ADDR_W'(ADDR0)) return;
        if (m_phase != 1) begin
            m_k = 0;
            m_fail = 0;
            m_phase = 1;
        end
        ok = (a == addr_of(m_k)) && (d == fib(m_k));
        if (!ok) begin
            if (m_fail < 255) m_fail++;
            m_err = 1'b1;
        end
        last = (m_k == NUM_VALUES - 1);
        if (last && m_fail == 0) m_pass = (m_pass + 1) % 256;
        exp_q.push_back(rec_t'({ok, fib(m_k), d, 8'(m_fail), m_err, last, 8'(m_pass)}));
        m_k++;
        if (last) m_phase = 2;
    endtask

    // one cycle of port-B activity; rd_data answers the previous cycle's address
    task automatic step(logic en, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        @(negedge clock);
        rd_data   = next_data;
        rd_en     = en;
        rd_addr   = a;
        next_data = d;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, ADDR_W'($urandom), DATA_W'($urandom));
    endtask

    task automatic rd(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, int hold, int gap);
        model_txn(a, d);
        repeat (hold) step(1'b1, a, d);
        idle(gap);
    endtask

    task automatic run_pass(int hold_max, int gap_max, bit corrupt);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int g;
        for (int k = 0; k < NUM_VALUES; k++) begin
            a = addr_of(k);
            d = fib(k);
            g = $urandom_range(gap_max, 0);
            if (corrupt && $urandom_range(3, 0) == 0) begin
                if (k != 0 && $urandom_range(1, 0) == 1)
                    a = a ^ ADDR_W'(1 << $urandom_range(ADDR_W - 1, 0));
                else
                    d = d ^ DATA_W'(1 << $urandom_range(DATA_W - 1, 0));
                idle(1);
                if (g == 0) g = 1;
            end
            rd(a, d, $urandom_range(hold_max, 1), g);
        end
        idle(4);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        rd_en = 1'b0;
        rd_addr = '0;
        rd_data = '0;
        next_data = '0;
        m_phase = 0;
        m_k = 0;
        m_fail = 0;
        m_pass = 0;
        m_err = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({chk_valid, chk_ok, exp_data, last_data, fail_cnt, error, done, pass_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b ok=%b exp=%0d data=%0d fail=%0d err=%b done=%b pass=%0d, want all 0",
                     chk_valid, chk_ok, exp_data, last_data, fail_cnt, error, done, pass_cnt);
        end
    endtask

    task automatic test_clean_pass();
        rec_t e, o;
        int n = 0;
        do_reset();
        for (int k = 0; k < NUM_VALUES; k++) rd(addr_of(k), fib(k), 3, 0);
        idle(4);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL clean_pass chk%0d: got %s, want %s", n, fmt(o), fmt(e)); end
            n++;
        end
        checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0 || n != NUM_VALUES) begin
            errors++;
            $display("FAIL clean_pass count: got %0d matched, %0d extra observed, %0d missing, want %0d", n, obs_q.size(), exp_q.size(), NUM_VALUES);
        end
        checks++;
        if ({done, pass_cnt, error, fail_cnt} !== {1'b1, 8'd1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL clean_pass status: got done=%b pass=%0d err=%b fail=%0d, want done=1 pass=1 err=0 fail=0", done, pass_cnt, error, fail_cnt);
        end
        obs_cyc.delete();
    endtask

    task automatic test_data_corrupt();
        rec_t e, o;
        int n = 0;
        do_reset();
        for (int k = 0; k < NUM_VALUES; k++) rd(addr_of(k), (k == 5) ? DATA_W'(6) : fib(k), 3, 0);
        idle(4);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL data_corrupt chk%0d: got %s, want %s", n, fmt(o), fmt(e)); end
            n++;
        end
        checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL data_corrupt count: got %0d extra observed, %0d missing, want 0 and 0", obs_q.size(), exp_q.size());
        end
        checks++;
        if ({done, pass_cnt, error, fail_cnt} !== {1'b1, 8'd0, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL data_corrupt status: got done=%b pass=%0d err=%b fail=%0d, want done=1 pass=0 err=1 fail=1", done, pass_cnt, error, fail_cnt);
        end
        obs_cyc.delete();
    endtask

    task automatic test_addr_error();
        rec_t e, o;
        int n = 0;
        do_reset();
        for (int k = 0; k < NUM_VALUES; k++)
            rd((k == 3) ? ADDR_W'(3000) : addr_of(k), fib(k), 2, 1);
        idle(4);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL addr_error chk%0d: got %s, want %s", n, fmt(o), fmt(e)); end
            n++;
        end
        checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL addr_error count: got %0d extra observed, %0d missing, want 0 and 0", obs_q.size(), exp_q.size());
        end
        checks++;
        if ({fail_cnt, error, pass_cnt} !== {8'd1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL addr_error status: got fail=%0d err=%b pass=%0d, want fail=1 err=1 pass=0", fail_cnt, error, pass_cnt);
        end
        obs_cyc.delete();
    endtask

    task automatic test_back_to_back();
        rec_t e, o;
        int n = 0;
        do_reset();
        for (int k = 0; k < 4; k++) rd(addr_of(k), fib(k), 1, 0);
        idle(4);
        checks++;
        if (obs_cyc.size() != 4) begin
            errors++;
            $display("FAIL back_to_back pulses: got %0d, want 4", obs_cyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (obs_cyc[i] != obs_cyc[0] + i) begin
                    errors++;
                    $display("FAIL back_to_back spacing%0d: got cycle %0d, want %0d", i, obs_cyc[i], obs_cyc[0] + i);
                end
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL back_to_back chk%0d: got %s, want %s", n, fmt(o), fmt(e)); end
            n++;
        end
        obs_q.delete();
        exp_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset_mid_pass();
        rec_t e, o;
        int n = 0;
        do_reset();
        for (int k = 0; k < 5; k++) rd(addr_of(k), fib(k), 2, 0);
        idle(4);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL mid_reset pre chk%0d: got %s, want %s", n, fmt(o), fmt(e)); end
            n++;
        end
        checks++;
        if (n != 5 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset pre count: got %0d matched %0d extra, want 5 and 0", n, obs_q.size());
        end
        // sixth read goes in flight, then reset lands before its result
        step(1'b1, addr_of(5), fib(5));
        @(negedge clock);
        reset = 1'b1;
        rd_en = 1'b0;
        #1;
        checks++;
        if ({chk_valid, chk_ok, exp_data, last_data, fail_cnt, error, done, pass_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset outputs: got valid=%b ok=%b exp=%0d data=%0d fail=%0d err=%b done=%b pass=%0d, want all 0",
                     chk_valid, chk_ok, exp_data, last_data, fail_cnt, error, done, pass_cnt);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        next_data = '0;
        m_phase = 0; m_k = 0; m_fail = 0; m_pass = 0; m_err = 1'b0;
        idle(5);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset stray_pulse: got %0d pulses, want 0", obs_q.size());
        end
        obs_q.delete();
        obs_cyc.delete();
        run_pass(3, 1, 1'b0);
        n = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL mid_reset post chk%0d: got %s, want %s", n, fmt(o), fmt(e)); end
            n++;
        end
        checks++;
        if (n != NUM_VALUES || obs_q.size() != 0 || pass_cnt !== 8'd1) begin
            errors++;
            $display("FAIL mid_reset restart: got %0d checks %0d extra pass=%0d, want %0d 0 pass=1", n, obs_q.size(), pass_cnt, NUM_VALUES);
        end
        obs_cyc.delete();
    endtask

    task automatic test_wrap();
        rec_t e, o;
        int n = 0;
        do_reset();
        run_pass(3, 1, 1'b0);
        run_pass(2, 2, 1'b0);
        rd(ADDR_W'(1000), fib(1), 2, 0);
        idle(4);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL wrap chk%0d: got %s, want %s", n, fmt(o), fmt(e)); end
            n++;
        end
        checks++;
        if (n != 2 * NUM_VALUES || obs_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap count: got %0d matched %0d extra %0d missing, want %0d 0 0", n, obs_q.size(), exp_q.size(), 2 * NUM_VALUES);
        end
        checks++;
        if ({pass_cnt, fail_cnt, done} !== {8'd2, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL wrap status: got pass=%0d fail=%0d done=%b, want pass=2 fail=0 done=1", pass_cnt, fail_cnt, done);
        end
        obs_cyc.delete();
    endtask

    task automatic test_random();
        rec_t e, o;
        int n = 0;
        for (int p = 0; p < 8; p++) begin
            run_pass(4, 2, 1'b1);
            rd(ADDR_W'($urandom_range(32767, 1)), DATA_W'($urandom), $urandom_range(3, 1), 1);
            idle(3);
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++;
                if (o !== e) begin errors++; $display("FAIL random p%0d chk%0d: got %s, want %s", p, n, fmt(o), fmt(e)); end
                n++;
            end
            checks++;
            if (obs_q.size() != 0 || exp_q.size() != 0) begin
                errors++;
                $display("FAIL random p%0d count: got %0d extra observed, %0d missing, want 0 and 0", p, obs_q.size(), exp_q.size());
            end
            obs_q.delete();
            exp_q.delete();
            obs_cyc.delete();
        end
        checks++;
        if ({pass_cnt, fail_cnt, error, done} !== {8'(m_pass), 8'(m_fail), m_err, 1'b1}) begin
            errors++;
            $display("FAIL random status: got pass=%0d fail=%0d err=%b done=%b, want pass=%0d fail=%0d err=%b done=1",
                     pass_cnt, fail_cnt, error, done, m_pass, m_fail, m_err);
        end
    endtask

    task automatic test_pass_cnt_wrap();
        rec_t e, o;
        int bad = 0;
        do_reset();
        for (int p = 0; p < 256; p++) begin
            run_pass(1, 0, 1'b0);
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    if (bad < 4) $display("FAIL pass_wrap p%0d: got %s, want %s", p, fmt(o), fmt(e));
                end
            end
            if (obs_q.size() != 0 || exp_q.size() != 0) bad++;
            obs_q.delete();
            exp_q.delete();
            obs_cyc.delete();
            if (p == 254) begin
                checks++;
                if (pass_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL pass_wrap at255: got pass=%0d, want 255", pass_cnt);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pass_wrap records: got %0d bad records, want 0", bad);
        end
        checks++;
        if ({pass_cnt, done, error} !== {8'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL pass_wrap final: got pass=%0d done=%b err=%b, want pass=0 done=1 err=0", pass_cnt, done, error);
        end
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_data_corrupt();
        test_addr_error();
        test_back_to_back();
        test_reset_mid_pass();
        test_wrap();
        test_random();
        test_pass_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, want completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
